// File: rtl/brg_cgra_sdr_link_rx.sv
// rtl/brg_cgra_sdr_link_rx.sv - SDR link receive endpoint: credit-sized FIFO, core valid/yumi port, decimated token return
module brg_cgra_sdr_link_rx #(
    parameter int width_p                         = 32,
    parameter int lg_fifo_depth_p                 = 3,
    parameter int lg_credit_to_token_decimation_p = 0
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               io_v_i,
    input  logic [width_p-1:0] io_data_i,
    output logic               io_token_o,
    output logic               core_v_o,
    output logic [width_p-1:0] core_data_o,
    input  logic               core_yumi_i,
    output logic               overflow_o
);

    localparam int L     = lg_fifo_depth_p;
    localparam int D     = lg_credit_to_token_decimation_p;
    localparam int DEPTH = 2 ** L;

    logic [width_p-1:0] mem_q [DEPTH];
    logic [L:0]         rd_q, rd_d;
    logic [L:0]         wr_q, wr_d;
    logic               ovf_q, ovf_d;
    logic               token_q, token_d;
    logic               empty, full, deq, enq;

    // Extra pointer MSB separates the full case from the empty case.
    assign empty = (rd_q == wr_q);
    assign full  = (rd_q[L-1:0] == wr_q[L-1:0]) && (rd_q[L] != wr_q[L]);
    assign deq   = core_yumi_i & ~empty;
    assign enq   = io_v_i & (~full | deq);

    assign rd_d  = rd_q + {{L{1'b0}}, deq};
    assign wr_d  = wr_q + {{L{1'b0}}, enq};
    assign ovf_d = ovf_q | (io_v_i & full & ~deq);

    generate
        if (D == 0) begin : g_no_decim
            assign token_d = deq;
        end else begin : g_decim
            logic [D-1:0] dcnt_q;

            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    dcnt_q <= '0;
                end else if (deq) begin
                    dcnt_q <= dcnt_q + 1'b1;
                end
            end

            assign token_d = deq & (&dcnt_q);
        end
    endgenerate

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            ovf_q   <= 1'b0;
            token_q <= 1'b0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            ovf_q   <= ovf_d;
            token_q <= token_d;
        end
    end

    // Storage is deliberately unreset; the pointers alone define validity.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wr_q[L-1:0]] <= io_data_i;
        end
    end

    assign core_v_o    = ~empty;
    assign core_data_o = empty ? '0 : mem_q[rd_q[L-1:0]];
    assign io_token_o  = token_q;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_brg_cgra_sdr_link_rx.sv
// tb/tb_brg_cgra_sdr_link_rx.sv - self-checking bench for brg_cgra_sdr_link_rx (D=0 and D=2 instances on shared stimulus)
module tb_brg_cgra_sdr_link_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        io_v = 1'b0;
    logic [31:0] io_data = '0;
    logic        yumi = 1'b0;

    logic        tok_a, cv_a, ovf_a;
    logic [31:0] cd_a;
    logic        tok_b, cv_b, ovf_b;
    logic [31:0] cd_b;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mq[$];
    bit          ovf_exp = 0;
    bit          tok0_exp = 0;
    bit          tok2_exp = 0;
    int          ndeq = 0;
    int          tok0_seen = 0;
    int          tok2_seen = 0;
    int          credits = 8;

    always #5 clk = ~clk;

    brg_cgra_sdr_link_rx #(
        .width_p(32), .lg_fifo_depth_p(3), .lg_credit_to_token_decimation_p(0)
    ) dut_a (
        .clk_i(clk), .reset_n_i(rst_n), .io_v_i(io_v), .io_data_i(io_data),
        .io_token_o(tok_a), .core_v_o(cv_a), .core_data_o(cd_a),
        .core_yumi_i(yumi), .overflow_o(ovf_a)
    );

    brg_cgra_sdr_link_rx #(
        .width_p(32), .lg_fifo_depth_p(3), .lg_credit_to_token_decimation_p(2)
    ) dut_b (
        .clk_i(clk), .reset_n_i(rst_n), .io_v_i(io_v), .io_data_i(io_data),
        .io_token_o(tok_b), .core_v_o(cv_b), .core_data_o(cd_b),
        .core_yumi_i(yumi), .overflow_o(ovf_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] head;
        head = (mq.size() != 0) ? mq[0] : 32'h0;
        check("core_v_d0", 64'(cv_a), 64'(mq.size() != 0));
        check("core_data_d0", 64'(cd_a), 64'(head));
        check("token_d0", 64'(tok_a), 64'(tok0_exp));
        check("overflow_d0", 64'(ovf_a), 64'(ovf_exp));
        check("core_v_d2", 64'(cv_b), 64'(mq.size() != 0));
        check("core_data_d2", 64'(cd_b), 64'(head));
        check("token_d2", 64'(tok_b), 64'(tok2_exp));
        check("overflow_d2", 64'(ovf_b), 64'(ovf_exp));
        if (tok_a) tok0_seen++;
        if (tok_b) tok2_seen++;
    endtask

    // Reference: a word queue; a token follows each deq (D=0) or every 4th deq since reset (D=2).
    task automatic step(input bit v, input logic [31:0] d, input bit y);
        bit deq, full;
        io_v = v; io_data = d; yumi = y;
        @(posedge clk);
        full = (mq.size() == 8);
        deq  = y && (mq.size() != 0);
        if (deq) begin
            void'(mq.pop_front());
            ndeq++;
        end
        if (v && (!full || deq)) mq.push_back(d);
        else if (v) ovf_exp = 1;
        tok0_exp = deq;
        tok2_exp = deq && (ndeq % 4 == 0);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; io_v = 1'b1; io_data = $urandom; yumi = 1'b0;
        mq.delete();
        ovf_exp = 0; tok0_exp = 0; tok2_exp = 0;
        ndeq = 0; tok0_seen = 0; tok2_seen = 0;
        #1;
        check_all();
        for (int i = 0; i < 2; i++) begin
            io_data = $urandom;
            @(posedge clk);
            #1;
            check_all();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        bit v, y;

        // Reset, then single word with D=0 token timing
        do_reset();
        step(1, 32'hA5A5_0001, 0);
        step(0, $urandom, 1);
        step(0, $urandom, 0);

        // Fill to full, then simultaneous enq+deq while full
        for (int i = 0; i < 8; i++) step(1, 32'(i), 0);
        step(1, 32'd8, 1);
        check("occupancy_after_full_enq_deq", 64'(mq.size()), 64'd8);
        for (int i = 0; i < 8; i++) step(0, $urandom, 1);

        // Overflow: ninth word dropped, drain yields 0..7
        for (int i = 0; i < 8; i++) step(1, 32'(i), 0);
        step(1, 32'hDEAD_BEEF, 0);
        for (int i = 0; i < 8; i++) begin
            check("drain_order", 64'(cd_a), 64'(i));
            step(0, $urandom, 1);
        end
        step(0, $urandom, 0);

        // Mid-operation reset discards contents; D=2 decimation
        step(1, $urandom, 0);
        step(1, $urandom, 0);
        do_reset();
        for (int i = 0; i < 8; i++) step(1, $urandom, 0);
        for (int i = 0; i < 8; i++) step(0, $urandom, 1);
        step(0, $urandom, 0);
        check("d2_token_count", 64'(tok2_seen), 64'd2);
        check("d0_token_count", 64'(tok0_seen), 64'd8);

        // Random streaming with a compliant transmitter sized to the D=2 credit return
        do_reset();
        credits = 8;
        for (int c = 0; c < 10000; c++) begin
            v = (credits > 0) && ($urandom_range(0, 3) != 0);
            y = (mq.size() != 0) && ($urandom_range(0, 2) != 0);
            step(v, $urandom, y);
            if (v) credits--;
            if (tok2_exp) credits += 4;
        end
        for (int i = 0; i < 12; i++) step(0, $urandom, mq.size() != 0);
        check("rand_tokens_d0", 64'(tok0_seen), 64'(ndeq));
        check("rand_tokens_d2", 64'(tok2_seen), 64'(ndeq / 4));
        check("rand_no_overflow", 64'(ovf_a | ovf_b), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
